// File: rtl/ofs_plat_host_chan_c1_tx_arbiter.sv
// Round-robin arbiter sharing one c1 write-request TX port among NUM_PORTS requesters.
// Multi-line packets hold the grant from SOP to last beat; FIU almost-full stalls issue.
module ofs_plat_host_chan_c1_tx_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int HDR_WIDTH  = 80,
    parameter int DATA_WIDTH = 512,
    localparam int SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             in_valid,
    input  logic [NUM_PORTS-1:0]             in_sop,
    input  logic [2*NUM_PORTS-1:0]           in_len,
    input  logic [HDR_WIDTH*NUM_PORTS-1:0]   in_hdr,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0]  in_data,
    output logic [NUM_PORTS-1:0]             in_ready,
    input  logic                             c1TxAlmFull,
    output logic                             out_valid,
    output logic [HDR_WIDTH-1:0]             out_hdr,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]                 out_sel,
    output logic                             busy,
    output logic                             err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  state_q;
    logic [SEL_W-1:0]        rr_ptr_q;
    logic [SEL_W-1:0]        owner_q;
    logic [1:0]              beats_left_q;
    logic                    out_valid_q;
    logic [HDR_WIDTH-1:0]    out_hdr_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [SEL_W-1:0]        out_sel_q;
    logic                    err_q;

    logic [HDR_WIDTH-1:0]    hdr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]   data_arr [NUM_PORTS];
    logic [1:0]              len_arr  [NUM_PORTS];

    logic [SEL_W:0]          cand_idx;
    logic [SEL_W-1:0]        winner_sel;
    logic                    winner_found;
    logic [SEL_W-1:0]        grant_sel;
    logic                    grant_any;
    logic                    issue_ok;
    logic                    accept;
    logic                    acc_sop;
    logic [1:0]              acc_len;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign hdr_arr[gi]  = in_hdr[gi*HDR_WIDTH +: HDR_WIDTH];
            assign data_arr[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign len_arr[gi]  = in_len[gi*2 +: 2];
        end
    endgenerate

    // Rotating search starting at rr_ptr; the wider cand_idx avoids overflow before the wrap.
    always_comb begin
        cand_idx     = '0;
        winner_sel   = rr_ptr_q;
        winner_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_idx = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (cand_idx >= (SEL_W+1)'(NUM_PORTS)) begin
                cand_idx = cand_idx - (SEL_W+1)'(NUM_PORTS);
            end
            if (!winner_found && in_valid[cand_idx[SEL_W-1:0]]) begin
                winner_found = 1'b1;
                winner_sel   = cand_idx[SEL_W-1:0];
            end
        end
    end

    // While locked the owner keeps the grant even across its own valid bubbles.
    assign grant_sel = (state_q == ST_LOCKED) ? owner_q : winner_sel;
    assign grant_any = (state_q == ST_LOCKED) || winner_found;
    assign issue_ok  = reset_n && !c1TxAlmFull && grant_any;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign in_ready[gi] = issue_ok && (grant_sel == SEL_W'(gi));
        end
    endgenerate

    assign accept  = |(in_valid & in_ready);
    assign acc_sop = in_sop[grant_sel];
    assign acc_len = len_arr[grant_sel];

    function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
        if (p == SEL_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return p + SEL_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            beats_left_q <= '0;
            out_valid_q  <= 1'b0;
            out_hdr_q    <= '0;
            out_data_q   <= '0;
            out_sel_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_hdr_q  <= hdr_arr[grant_sel];
                out_data_q <= data_arr[grant_sel];
                out_sel_q  <= grant_sel;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        // cl_len 1 and 3 both have bit 0 set; 0 and the illegal 2 are single-line
                        if (acc_sop && acc_len[0]) begin
                            state_q      <= ST_LOCKED;
                            owner_q      <= grant_sel;
                            beats_left_q <= acc_len;
                        end else begin
                            rr_ptr_q <= next_port(grant_sel);
                            if (!acc_sop || (acc_len == 2'd2)) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        if (acc_sop) begin
                            err_q <= 1'b1;
                        end
                        beats_left_q <= beats_left_q - 2'd1;
                        if (beats_left_q == 2'd1) begin
                            state_q  <= ST_IDLE;
                            rr_ptr_q <= next_port(owner_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_hdr   = out_hdr_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q == ST_LOCKED);
    assign err       = err_q;

endmodule
